gpu_top_checking: RTL and testbench
===================================

Name: gpu_top_checking

Overview:
- Self-contained checking top of the GPU, loaded and observed entirely through FileIO ports.
- Contains four blocks:
  - 8-entry task manager (TM) queue.
  - 4096x32 instruction cache (ICache).
  - 256-bit-wide global + shared data memory.
  - Per-line cache-latency table.
- On start, a fetch engine walks each queued task's instruction stream in ICache until EXIT, then raises finished.

Parameters:
- mem_size, 256, number of global-memory lines. Also the number of latency-table entries.
- shmem_size, 256, number of shared-memory lines. They sit at addresses mem_size..mem_size+shmem_size-1.
- addr_width (localparam), $clog2(mem_size+shmem_size) = 9, FIO_ADDR width.
- mem_addr_width (localparam), $clog2(mem_size) = 8, FIO_CACHE_MEM_ADDR width.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  reset, synchronous and active-low.
- Write_Enable_FIO_TM  in  1  push Write_Data_FIO_TM into the TM queue.
- Write_Data_FIO_TM  in  29  task entry. [28:17] start PC (ICache word address); [16:0] ignored.
- start_FIO_TM  in  1  level start of task execution.
- clear_FIO_TM  in  1  empty the queue and drop finished.
- finished_TM_FIO  out  1  all queued tasks completed.
- FileIO_Wen_ICache  in  1  ICache write enable.
- FileIO_Addr_ICache  in  12  ICache word address.
- FileIO_Din_ICache  in  32  ICache write data.
- FileIO_Dout_ICache  out  32  ICache read data at FileIO_Addr_ICache.
- FIO_MEMWRITE  in  1  data-memory write enable.
- FIO_ADDR  in  addr_width  data-memory line address.
- FIO_WRITE_DATA  in  256  line write data.
- FIO_READ_DATA  out  256  line read data.
- FIO_CACHE_LAT_WRITE  in  1  latency-table write enable.
- FIO_CACHE_LAT_VALUE  in  5  latency value in cycles.
- FIO_CACHE_MEM_ADDR  in  mem_addr_width  latency-table index.

Behaviour:
- Reset (rst==0 at a clk edge):
  - TM count, read pointer and write pointer go to 0.
  - Engine goes to IDLE; finished_TM_FIO=0.
  - FIO_READ_DATA pipeline = 0; FileIO_Dout_ICache = 0.
  - Memory, ICache and latency-table contents are not reset.
  - Reset mid-run aborts the run immediately.
- ICache:
  - Write: FileIO_Wen_ICache=1 writes Din to [Addr] at the edge.
  - Read: FileIO_Dout_ICache = registered ICache[FileIO_Addr_ICache], 1-cycle latency. A write followed by a read of the same address returns the new data.
  - Second, internal read port for the engine: combinational.
- Data memory:
  - Write: FIO_MEMWRITE=1 writes the line at FIO_ADDR.
  - Read: FIO_READ_DATA = mem[FIO_ADDR] with 2-cycle latency (address register, then data register), always active.
  - A simultaneous write to the address being read returns the old data.
- Latency table:
  - FIO_CACHE_LAT_WRITE=1 stores VALUE at FIO_CACHE_MEM_ADDR.
  - The address is mem_addr_width bits, so out-of-range values handed in by a driver wrap modulo mem_size.
  - Read only through the EMU_DEBUG hierarchy; not used by the engine.
- TM queue:
  - A push while count<8 stores the entry at the write pointer and increments count.
  - A push at count==8 is dropped.
  - clear_FIO_TM=1 resets count and both pointers and deasserts finished. clear wins over a simultaneous push.
- Engine FSM (IDLE, LOAD, FETCH, DONE):
  - IDLE to LOAD when start_FIO_TM=1 and finished=0. If count==0, go to DONE instead.
  - LOAD: pc <= entry[read pointer][28:17]; fetch counter <= 0; then FETCH.
  - FETCH, one word per cycle: if ICache[pc]==32'h0 (EXIT) or fetch counter==4095, the task ends. Otherwise pc <= pc+1 (wraps at 4095) and counter increments.
  - Task end: read pointer increments. If tasks remain, go to LOAD; otherwise go to DONE.
  - DONE: finished_TM_FIO=1, held until clear or reset. Start is ignored while finished.
  - clear in any state returns the FSM to IDLE.
- Pushes during a run are accepted into the queue but the run's task total is latched at the IDLE to LOAD transition.

Optional Feature:
- Macro: GPU_CHECK_TRACE_EN.
- Defined: at every task end, $display prints the task index, start PC and number of instructions fetched; at DONE it prints the total cycles elapsed since start.
- Undefined: no simulation output; RTL is functionally identical either way.

Test Plan:
- Reset, then write ICache[5]=32'hDEADBEEF and set Addr=5 -> FileIO_Dout_ICache=32'hDEADBEEF one cycle after the address is applied.
- Write mem lines 0..255 with value i, then present FIO_ADDR=0..255 sequentially -> FIO_READ_DATA equals the address from 2 cycles earlier. Write line 300 -> readback is correct (shared region).
- Push 9 TM entries -> the 9th is dropped. Run with 8 tasks each at PC 0, where ICache[0..2] is nonzero and ICache[3]=0 -> finished rises 8*(1+4)+1 cycles after start.
- start with an empty queue -> finished=1 one cycle later. clear -> finished=0 the next cycle.
- Task PC=4094 with ICache[4094], [4095] and [0] nonzero and [1]=0 -> PC wraps and the task ends at word 1. All-nonzero ICache -> task ends after 4096 fetches.
- Deassert rst mid-FETCH -> next cycle finished=0 and FSM in IDLE. Memory contents are retained.

Source files
------------

// File: rtl/gpu_top_checking.sv
// rtl/gpu_top_checking.sv - GPU checking top: TM queue, ICache, data memory, latency table, fetch engine
// Optional trace output enabled by defining GPU_CHECK_TRACE_EN.
module gpu_top_checking #(
    parameter  int mem_size       = 256,
    parameter  int shmem_size     = 256,
    localparam int addr_width     = $clog2(mem_size + shmem_size),
    localparam int mem_addr_width = $clog2(mem_size)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      Write_Enable_FIO_TM,
    input  logic [28:0]               Write_Data_FIO_TM,
    input  logic                      start_FIO_TM,
    input  logic                      clear_FIO_TM,
    output logic                      finished_TM_FIO,
    input  logic                      FileIO_Wen_ICache,
    input  logic [11:0]               FileIO_Addr_ICache,
    input  logic [31:0]               FileIO_Din_ICache,
    output logic [31:0]               FileIO_Dout_ICache,
    input  logic                      FIO_MEMWRITE,
    input  logic [addr_width-1:0]     FIO_ADDR,
    input  logic [255:0]              FIO_WRITE_DATA,
    output logic [255:0]              FIO_READ_DATA,
    input  logic                      FIO_CACHE_LAT_WRITE,
    input  logic [4:0]                FIO_CACHE_LAT_VALUE,
    input  logic [mem_addr_width-1:0] FIO_CACHE_MEM_ADDR
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FETCH, S_DONE} state_e;

    logic [31:0]  icache_mem [4096];
    logic [255:0] data_mem   [mem_size + shmem_size];
    logic [4:0]   lat_mem    [mem_size];
    logic [11:0]  tm_pc_mem  [8];

    state_e                  state_q, state_d;
    logic [11:0]             pc_q, pc_d;
    logic [11:0]             fetch_cnt_q, fetch_cnt_d;
    logic [3:0]              count_q, count_d;
    logic [2:0]              wr_ptr_q, wr_ptr_d;
    logic [2:0]              rd_ptr_q, rd_ptr_d;
    logic [3:0]              total_q, total_d;
    logic [3:0]              tasks_done_q, tasks_done_d;
    logic [addr_width-1:0]   rd_addr_q, rd_addr_d;
    logic [255:0]            rd_data_q, rd_data_d;
    logic [31:0]             ic_dout_q, ic_dout_d;
    logic                    push_en;
    logic                    task_end;
    logic [31:0]             fetch_word;

    // Only the start PC of a task entry is kept; the low bits are don't-care.
    logic                    unused_tm_bits;
    logic [4:0]              lat_dbg_unused;
    assign unused_tm_bits = ^Write_Data_FIO_TM[16:0];
    assign lat_dbg_unused = lat_mem[FIO_CACHE_MEM_ADDR];

    always_ff @(posedge clk) begin
        if (FileIO_Wen_ICache) icache_mem[FileIO_Addr_ICache] <= FileIO_Din_ICache;
        if (FIO_MEMWRITE) data_mem[FIO_ADDR] <= FIO_WRITE_DATA;
        if (FIO_CACHE_LAT_WRITE) lat_mem[FIO_CACHE_MEM_ADDR] <= FIO_CACHE_LAT_VALUE;
        if (push_en) tm_pc_mem[wr_ptr_q] <= Write_Data_FIO_TM[28:17];
    end

    assign fetch_word = icache_mem[pc_q];

    always_comb begin
        rd_addr_d = FIO_ADDR;
        rd_data_d = data_mem[rd_addr_q];
        ic_dout_d = icache_mem[FileIO_Addr_ICache];
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_cnt_d  = fetch_cnt_q;
        count_d      = count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        total_d      = total_q;
        tasks_done_d = tasks_done_q;
        push_en      = 1'b0;
        task_end     = 1'b0;

        if (Write_Enable_FIO_TM && (count_q < 4'd8)) begin
            push_en  = 1'b1;
            count_d  = count_q + 4'd1;
            wr_ptr_d = wr_ptr_q + 3'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_FIO_TM) begin
                    if (count_q == 4'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d      = S_LOAD;
                        total_d      = count_q;
                        tasks_done_d = 4'd0;
                    end
                end
            end
            S_LOAD: begin
                pc_d        = tm_pc_mem[rd_ptr_q];
                fetch_cnt_d = 12'd0;
                state_d     = S_FETCH;
            end
            S_FETCH: begin
                if ((fetch_word == 32'h0) || (fetch_cnt_q == 12'hFFF)) begin
                    task_end = 1'b1;
                end else begin
                    pc_d        = pc_q + 12'd1;
                    fetch_cnt_d = fetch_cnt_q + 12'd1;
                end
            end
            default: ;
        endcase

        if (task_end) begin
            rd_ptr_d     = rd_ptr_q + 3'd1;
            tasks_done_d = tasks_done_q + 4'd1;
            state_d      = ((tasks_done_q + 4'd1) < total_q) ? S_LOAD : S_DONE;
        end

        // Clear beats a same-cycle push and aborts any run in progress.
        if (clear_FIO_TM) begin
            count_d  = 4'd0;
            wr_ptr_d = 3'd0;
            rd_ptr_d = 3'd0;
            push_en  = 1'b0;
            state_d  = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            pc_q         <= 12'd0;
            fetch_cnt_q  <= 12'd0;
            count_q      <= 4'd0;
            wr_ptr_q     <= 3'd0;
            rd_ptr_q     <= 3'd0;
            total_q      <= 4'd0;
            tasks_done_q <= 4'd0;
            rd_addr_q    <= '0;
            rd_data_q    <= '0;
            ic_dout_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_cnt_q  <= fetch_cnt_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            total_q      <= total_d;
            tasks_done_q <= tasks_done_d;
            rd_addr_q    <= rd_addr_d;
            rd_data_q    <= rd_data_d;
            ic_dout_q    <= ic_dout_d;
        end
    end

    assign finished_TM_FIO    = (state_q == S_DONE);
    assign FIO_READ_DATA      = rd_data_q;
    assign FileIO_Dout_ICache = ic_dout_q;

`ifdef GPU_CHECK_TRACE_EN
    logic [31:0] trace_cycles_q;
    logic [11:0] trace_start_pc_q;

    always_ff @(posedge clk) begin
        if (!rst || (state_q == S_IDLE)) trace_cycles_q <= 32'd0;
        else trace_cycles_q <= trace_cycles_q + 32'd1;
        if (state_q == S_LOAD) trace_start_pc_q <= pc_d;
        if (rst && !clear_FIO_TM && task_end)
            $display("trace: task %0d start_pc %0d fetched %0d",
                     tasks_done_q, trace_start_pc_q, {1'b0, fetch_cnt_q} + 13'd1);
        if (rst && !clear_FIO_TM && (state_q != S_DONE) && (state_d == S_DONE))
            $display("trace: done after %0d cycles", trace_cycles_q + 32'd1);
    end
`endif

endmodule

// File: tb/tb_gpu_top_checking.sv
// tb/tb_gpu_top_checking.sv - randomized self-checking bench for gpu_top_checking
module tb_gpu_top_checking;

    logic         clk = 1'b0;
    logic         rst;
    logic         Write_Enable_FIO_TM;
    logic [28:0]  Write_Data_FIO_TM;
    logic         start_FIO_TM;
    logic         clear_FIO_TM;
    logic         finished_TM_FIO;
    logic         FileIO_Wen_ICache;
    logic [11:0]  FileIO_Addr_ICache;
    logic [31:0]  FileIO_Din_ICache;
    logic [31:0]  FileIO_Dout_ICache;
    logic         FIO_MEMWRITE;
    logic [8:0]   FIO_ADDR;
    logic [255:0] FIO_WRITE_DATA;
    logic [255:0] FIO_READ_DATA;
    logic         FIO_CACHE_LAT_WRITE;
    logic [4:0]   FIO_CACHE_LAT_VALUE;
    logic [7:0]   FIO_CACHE_MEM_ADDR;

    int checks = 0;
    int passes = 0;

    logic [31:0]  ic_m  [4096];
    logic [255:0] mem_m [512];
    int           tq_m  [$];

    gpu_top_checking dut (
        .clk                 (clk),
        .rst                 (rst),
        .Write_Enable_FIO_TM (Write_Enable_FIO_TM),
        .Write_Data_FIO_TM   (Write_Data_FIO_TM),
        .start_FIO_TM        (start_FIO_TM),
        .clear_FIO_TM        (clear_FIO_TM),
        .finished_TM_FIO     (finished_TM_FIO),
        .FileIO_Wen_ICache   (FileIO_Wen_ICache),
        .FileIO_Addr_ICache  (FileIO_Addr_ICache),
        .FileIO_Din_ICache   (FileIO_Din_ICache),
        .FileIO_Dout_ICache  (FileIO_Dout_ICache),
        .FIO_MEMWRITE        (FIO_MEMWRITE),
        .FIO_ADDR            (FIO_ADDR),
        .FIO_WRITE_DATA      (FIO_WRITE_DATA),
        .FIO_READ_DATA       (FIO_READ_DATA),
        .FIO_CACHE_LAT_WRITE (FIO_CACHE_LAT_WRITE),
        .FIO_CACHE_LAT_VALUE (FIO_CACHE_LAT_VALUE),
        .FIO_CACHE_MEM_ADDR  (FIO_CACHE_MEM_ADDR)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ic_write(input int addr, input logic [31:0] data);
        FileIO_Wen_ICache  = 1'b1;
        FileIO_Addr_ICache = 12'(addr);
        FileIO_Din_ICache  = data;
        tick();
        FileIO_Wen_ICache  = 1'b0;
        ic_m[addr] = data;
    endtask

    task automatic mem_write(input int addr, input logic [255:0] data);
        FIO_MEMWRITE   = 1'b1;
        FIO_ADDR       = 9'(addr);
        FIO_WRITE_DATA = data;
        tick();
        FIO_MEMWRITE   = 1'b0;
        mem_m[addr] = data;
    endtask

    task automatic tm_push(input int pc);
        Write_Enable_FIO_TM = 1'b1;
        Write_Data_FIO_TM   = {12'(pc), 17'($urandom)};
        tick();
        Write_Enable_FIO_TM = 1'b0;
        if (tq_m.size() < 8) tq_m.push_back(pc);
    endtask

    task automatic tm_clear();
        clear_FIO_TM = 1'b1;
        tick();
        clear_FIO_TM = 1'b0;
        tq_m.delete();
    endtask

    // Instruction words fetched by one task: walk until EXIT or 4096 words.
    function automatic int model_fetches(input int pc);
        int  n = 0;
        int  p = pc;
        bit  stop = 1'b0;
        while (!stop) begin
            n++;
            if (ic_m[p] == 32'h0 || n == 4096) stop = 1'b1;
            else p = (p + 1) % 4096;
        end
        return n;
    endfunction

    // Edges from the start edge to finished: one for the start, then LOAD plus fetches per task.
    function automatic int model_run_cycles();
        int total = 1;
        foreach (tq_m[i]) total += 1 + model_fetches(tq_m[i]);
        return total;
    endfunction

    // Holds start, optionally pushes one more task mid-run; cycles=-1 on timeout.
    task automatic run_measure(input int budget, input bit do_push, input int push_pc,
                               output int cycles);
        bit stop = 1'b0;
        cycles = 0;
        start_FIO_TM = 1'b1;
        while (!stop) begin
            if (do_push && cycles == 2) begin
                Write_Enable_FIO_TM = 1'b1;
                Write_Data_FIO_TM   = {12'(push_pc), 17'($urandom)};
            end else begin
                Write_Enable_FIO_TM = 1'b0;
            end
            tick();
            cycles++;
            if (finished_TM_FIO) stop = 1'b1;
            else if (cycles >= budget) begin
                cycles = -1;
                stop = 1'b1;
            end
        end
        Write_Enable_FIO_TM = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (finished_TM_FIO !== 1'b0) $display("FAIL reset_finished got %b want 0", finished_TM_FIO);
        else passes++;
        checks++;
        if (FileIO_Dout_ICache !== 32'h0) $display("FAIL reset_ic_dout got %h want 0", FileIO_Dout_ICache);
        else passes++;
        checks++;
        if (FIO_READ_DATA !== 256'h0) $display("FAIL reset_read_data got %h want 0", FIO_READ_DATA);
        else passes++;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_icache();
        int addrs [8];
        ic_write(5, 32'hDEADBEEF);
        FileIO_Addr_ICache = 12'd5;
        tick();
        checks++;
        if (FileIO_Dout_ICache !== 32'hDEADBEEF)
            $display("FAIL icache_5 got %h want deadbeef", FileIO_Dout_ICache);
        else passes++;
        for (int i = 0; i < 8; i++) begin
            addrs[i] = 200 + int'($urandom_range(0, 3000));
            ic_write(addrs[i], $urandom | 32'h1);
        end
        for (int i = 0; i < 8; i++) begin
            FileIO_Addr_ICache = 12'(addrs[i]);
            tick();
            checks++;
            if (FileIO_Dout_ICache !== ic_m[addrs[i]])
                $display("FAIL icache_rand[%0d] got %h want %h", addrs[i], FileIO_Dout_ICache, ic_m[addrs[i]]);
            else passes++;
        end
    endtask

    task automatic test_memory();
        logic [255:0] line;
        logic [255:0] old_line;
        for (int i = 0; i < 256; i++) mem_write(i, 256'(i));
        for (int k = 0; k <= 256; k++) begin
            FIO_ADDR = 9'(k < 256 ? k : 0);
            tick();
            if (k >= 1) begin
                checks++;
                if (FIO_READ_DATA !== mem_m[k-1])
                    $display("FAIL mem_sweep[%0d] got %h want %h", k - 1, FIO_READ_DATA, mem_m[k-1]);
                else passes++;
            end
        end
        line = {8{$urandom}};
        mem_write(300, line);
        FIO_ADDR = 9'd300;
        tick();
        tick();
        checks++;
        if (FIO_READ_DATA !== mem_m[300]) $display("FAIL mem_shared got %h want %h", FIO_READ_DATA, mem_m[300]);
        else passes++;
        // Write into the line already captured by the address stage.
        old_line = mem_m[300];
        line = {8{$urandom}};
        mem_write(300, line);
        checks++;
        if (FIO_READ_DATA !== old_line) $display("FAIL mem_rw_old got %h want %h", FIO_READ_DATA, old_line);
        else passes++;
        tick();
        checks++;
        if (FIO_READ_DATA !== line) $display("FAIL mem_rw_new got %h want %h", FIO_READ_DATA, line);
        else passes++;
        for (int i = 0; i < 4; i++) begin
            FIO_CACHE_LAT_WRITE = 1'b1;
            FIO_CACHE_MEM_ADDR  = 8'($urandom);
            FIO_CACHE_LAT_VALUE = 5'($urandom);
            tick();
        end
        FIO_CACHE_LAT_WRITE = 1'b0;
    endtask

    task automatic test_empty_start();
        int cyc;
        tm_clear();
        run_measure(10, 1'b0, 0, cyc);
        checks++;
        if (cyc !== 1) $display("FAIL empty_start got %0d cycles want 1", cyc);
        else passes++;
        tick();
        checks++;
        if (finished_TM_FIO !== 1'b1) $display("FAIL finished_hold got %b want 1", finished_TM_FIO);
        else passes++;
        start_FIO_TM = 1'b0;
        clear_FIO_TM = 1'b1;
        Write_Enable_FIO_TM = 1'b1;
        Write_Data_FIO_TM = 29'h0;
        tick();
        clear_FIO_TM = 1'b0;
        Write_Enable_FIO_TM = 1'b0;
        tq_m.delete();
        checks++;
        if (finished_TM_FIO !== 1'b0) $display("FAIL clear_finished got %b want 0", finished_TM_FIO);
        else passes++;
        run_measure(10, 1'b0, 0, cyc);
        checks++;
        if (cyc !== 1) $display("FAIL clear_beats_push got %0d cycles want 1", cyc);
        else passes++;
        start_FIO_TM = 1'b0;
        tm_clear();
    endtask

    task automatic test_queue_overflow();
        int cyc;
        int exp;
        ic_write(0, 32'h1111);
        ic_write(1, 32'h2222);
        ic_write(2, 32'h3333);
        ic_write(3, 32'h0);
        ic_write(100, 32'h0);
        tm_clear();
        for (int i = 0; i < 8; i++) tm_push(0);
        tm_push(100);
        exp = model_run_cycles();
        run_measure(200, 1'b0, 0, cyc);
        checks++;
        if (cyc !== exp || exp !== 41) $display("FAIL overflow_run got %0d cycles want %0d", cyc, exp);
        else passes++;
        start_FIO_TM = 1'b0;
        tm_clear();
    endtask

    task automatic test_pc_wrap();
        int cyc;
        int exp;
        ic_write(4094, 32'hA);
        ic_write(4095, 32'hB);
        ic_write(0, 32'hC);
        ic_write(1, 32'h0);
        tm_clear();
        tm_push(4094);
        exp = model_run_cycles();
        run_measure(100, 1'b0, 0, cyc);
        checks++;
        if (cyc !== exp || exp !== 6) $display("FAIL pc_wrap got %0d cycles want %0d", cyc, exp);
        else passes++;
        start_FIO_TM = 1'b0;
        tm_clear();
    endtask

    task automatic test_random_tasks();
        int cyc;
        int exp;
        int n;
        for (int r = 0; r < 4; r++) begin
            for (int a = 0; a < 63; a++)
                ic_write(a, ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom | 32'h1));
            ic_write(63, 32'h0);
            tm_clear();
            n = int'($urandom_range(1, 7));
            for (int t = 0; t < n; t++) tm_push(int'($urandom_range(0, 62)));
            exp = model_run_cycles();
            run_measure(2000, (r % 2) == 1, int'($urandom_range(0, 62)), cyc);
            checks++;
            if (cyc !== exp) $display("FAIL random_run[%0d] got %0d cycles want %0d", r, cyc, exp);
            else passes++;
            start_FIO_TM = 1'b0;
            tm_clear();
        end
    endtask

    task automatic test_all_nonzero();
        int cyc;
        int exp;
        for (int a = 0; a < 4096; a++) ic_write(a, $urandom | 32'h80000000);
        tm_clear();
        tm_push(int'($urandom_range(0, 4095)));
        exp = model_run_cycles();
        run_measure(5000, 1'b0, 0, cyc);
        checks++;
        if (cyc !== exp || exp !== 4098) $display("FAIL all_nonzero got %0d cycles want %0d", cyc, exp);
        else passes++;
        start_FIO_TM = 1'b0;
        tm_clear();
    endtask

    task automatic test_reset_midrun();
        int cyc;
        tm_push(17);
        start_FIO_TM = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        rst = 1'b0;
        start_FIO_TM = 1'b0;
        tick();
        rst = 1'b1;
        tq_m.delete();
        checks++;
        if (finished_TM_FIO !== 1'b0) $display("FAIL midrun_reset_finished got %b want 0", finished_TM_FIO);
        else passes++;
        run_measure(10, 1'b0, 0, cyc);
        checks++;
        if (cyc !== 1) $display("FAIL midrun_reset_idle got %0d cycles want 1", cyc);
        else passes++;
        start_FIO_TM = 1'b0;
        tm_clear();
        FIO_ADDR = 9'd300;
        tick();
        tick();
        checks++;
        if (FIO_READ_DATA !== mem_m[300]) $display("FAIL retain_mem300 got %h want %h", FIO_READ_DATA, mem_m[300]);
        else passes++;
        FIO_ADDR = 9'd77;
        tick();
        tick();
        checks++;
        if (FIO_READ_DATA !== mem_m[77]) $display("FAIL retain_mem77 got %h want %h", FIO_READ_DATA, mem_m[77]);
        else passes++;
        FileIO_Addr_ICache = 12'd1234;
        tick();
        checks++;
        if (FileIO_Dout_ICache !== ic_m[1234])
            $display("FAIL retain_icache got %h want %h", FileIO_Dout_ICache, ic_m[1234]);
        else passes++;
    endtask

    initial begin
        rst                 = 1'b0;
        Write_Enable_FIO_TM = 1'b0;
        Write_Data_FIO_TM   = '0;
        start_FIO_TM        = 1'b0;
        clear_FIO_TM        = 1'b0;
        FileIO_Wen_ICache   = 1'b0;
        FileIO_Addr_ICache  = '0;
        FileIO_Din_ICache   = '0;
        FIO_MEMWRITE        = 1'b0;
        FIO_ADDR            = '0;
        FIO_WRITE_DATA      = '0;
        FIO_CACHE_LAT_WRITE = 1'b0;
        FIO_CACHE_LAT_VALUE = '0;
        FIO_CACHE_MEM_ADDR  = '0;
        foreach (ic_m[i]) ic_m[i] = 32'h0;
        foreach (mem_m[i]) mem_m[i] = 256'h0;

        test_reset();
        test_icache();
        test_memory();
        test_empty_start();
        test_queue_overflow();
        test_pc_wrap();
        test_random_tasks();
        test_all_nonzero();
        test_reset_midrun();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
